// File: rtl/set_bit_enumerator_if.sv
// Handshake bundle for set_bit_enumerator: word input channel, index output
// channel and the per-word done/count report.
interface set_bit_enumerator_if #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5,
    parameter int CNT_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             done;
    logic [CNT_W-1:0] done_count;

    // Producer/consumer side
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_idx, out_last, done, done_count
    );

    // Enumerator side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_idx, out_last, done, done_count
    );
endinterface

// File: rtl/set_bit_enumerator.sv
// Expands a word into the indices of its set bits, LSB first, one per accepted
// beat, then reports the number of indices emitted with a one-cycle done pulse.
module set_bit_enumerator #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5,
    parameter int CNT_W = 6
) (
    input logic                 clk,
    input logic                 rst_n,
    set_bit_enumerator_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] w_shadow_nxt;
    logic [WIDTH-1:0] w_shadow_drop;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_last;
    logic [IDX_W-1:0] w_low_idx;

    // Scanning downward leaves the lowest set bit as the final assignment.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    assign w_shadow_drop = r_shadow & (r_shadow - WIDTH'(1));
    assign w_last        = (w_shadow_drop == '0);
    assign w_low_idx     = lowest_set(r_shadow);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_shadow <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_shadow <= w_shadow_nxt;
            r_count  <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shadow_nxt = r_shadow;
        w_count_nxt  = r_count;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_shadow_nxt = bus.in_data;
                    w_count_nxt  = '0;
                    w_state_nxt  = (bus.in_data != '0) ? S_SCAN : S_DONE;
                end
            end
            S_SCAN: begin
                if (bus.out_ready) begin
                    w_shadow_nxt = w_shadow_drop;
                    w_count_nxt  = r_count + CNT_W'(1);
                    if (w_last) w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs depend on registered state only; index/last are zeroed outside SCAN.
    assign bus.in_ready   = (r_state == S_IDLE);
    assign bus.out_valid  = (r_state == S_SCAN);
    assign bus.out_idx    = (r_state == S_SCAN) ? w_low_idx : '0;
    assign bus.out_last   = (r_state == S_SCAN) && w_last;
    assign bus.done       = (r_state == S_DONE);
    assign bus.done_count = (r_state == S_DONE) ? r_count : '0;

endmodule
